data_aligner_sched: RTL
=======================

# data_aligner_sched

Run-time controller for the two-stream data aligner. It gates the aligner's input valids, tracks the word skew between the 1st and 2d streams, and watches the FIFO status bits and output progress. When the streams drift apart or stall, it flushes the aligner and resynchronises both streams on a common start word. It sits between the stream sources and the aligner's input interface and observes the aligner's output interface.

## Interface
Parameters:
- SKEW_MAX, 8: largest tolerated |accepted 1st words − accepted 2d words|.
- TIMEOUT, 256: cycles with nonzero skew and no vld_o before a flush.
- FLUSH_CYCLES, 4: width of the flush_o pulse in cycles.
- CNT_W, 8: width of the signed skew counter and of err_cnt_o. Requires SKEW_MAX < 2^(CNT_W-1)-1.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous reset, active-high.
- en_i, in, 1: enables operation.
- vld_1st_i, in, 1: raw valid of the 1st stream.
- vld_2d_i, in, 1: raw valid of the 2d stream.
- vld_o_i, in, 1: aligned output valid from the aligner.
- statuses_i, in, 2: aligner FIFO status. Bit0 = 1st FIFO full, bit1 = 2d FIFO full.
- gate_1st_o, out, 1: AND-mask for vld_1st into the aligner.
- gate_2d_o, out, 1: AND-mask for vld_2d into the aligner.
- flush_o, out, 1: aligner FIFO flush request.
- state_o, out, 2: current FSM state.
- skew_o, out, CNT_W signed: current skew.
- cause_o, out, 2: cause of the last error flush. 00 none, 01 status, 10 skew, 11 timeout.
- err_cnt_o, out, CNT_W: saturating count of error flushes.

## Operation
- States (package enum): IDLE=0, FLUSH=1, SYNC=2, RUN=3.
- IDLE: gates 0, flush_o 0. en_i=1 → FLUSH. This start-up flush is not an error.
- FLUSH:
  - flush_o=1, gates 0.
  - Skew and timer are held at 0.
  - After FLUSH_CYCLES cycles → SYNC.
- SYNC:
  - Gates 0.
  - A cycle with vld_1st_i & vld_2d_i both high → RUN.
  - That pair is dropped. Lone valids are dropped.
- RUN:
  - Gates 1.
  - Skew: +1 on vld_1st_i only, −1 on vld_2d_i only, unchanged on both or neither. Saturates at ±(2^(CNT_W-1)-1).
  - Timer: cleared when vld_o_i=1 or skew==0; otherwise increments.
- Error check in RUN, on registered values, in priority order:
  1. statuses_i≠0 → cause 01.
  2. |skew|>SKEW_MAX → cause 10.
  3. timer==TIMEOUT → cause 11.
- On any error: → FLUSH, cause_o updated, err_cnt_o+1 (saturates at all-ones).
- en_i=0 in any state → IDLE next cycle. This overrides everything, including an in-progress flush.
- Re-enabling always passes through FLUSH.
- cause_o and err_cnt_o persist until rst.

## Timing
- All outputs are registered.
- Reset values: state IDLE, gates 0, flush_o 0, skew 0, timer 0, cause 00, err_cnt 0.
- A state change takes effect on outputs the cycle after its condition.
- The gates drop in the first FLUSH cycle. Words arriving in the trigger cycle are still counted, then flushed.
- flush_o is high for exactly FLUSH_CYCLES consecutive cycles unless en_i drops. If en_i drops, flush_o is 0 the next cycle.
- RUN gates open the cycle after the sync pair.
- Skew boundaries:
  - |skew|==SKEW_MAX: no action.
  - SKEW_MAX+1 registered: FLUSH on the next edge.
- Timer boundary: vld_o_i in the same cycle as timer==TIMEOUT-1 prevents the timeout.
- Simultaneous error causes: the highest-priority cause is recorded, and err_cnt increments once.
- rst mid-flush: outputs return to reset values on the next edge.

## Structure
- data_aligner_pkg holds:
  - the sched_state_t enum;
  - the flush_cause_t enum (NONE, STATUS, SKEW, TIMEOUT);
  - the status bit index constants.
- Sub-module aligner_skew_counter: signed saturating up/down counter with sync clear. Ports: clk, rst, clr, inc, dec, cnt.
- The FSM, timer, and error logic live in the top module.

## Test plan
1. Reset held 3 cycles → all outputs 0, state_o=0. Release with en_i=0 → outputs stay at reset values.
2. en_i=1 → flush_o=1 for exactly 4 cycles. Then SYNC. Three lone vld_1st_i → gates stay 0. Both valid at cycle N → state_o=3 and gates=1 at N+1, skew_o=0.
3. RUN, 9 consecutive vld_1st_i-only cycles → skew_o reaches 9. FLUSH the next cycle, cause_o=10, err_cnt_o=1. 8 words only → stays in RUN.
4. RUN with statuses_i=2'b01 and skew=9 in the same cycle → FLUSH, cause_o=01, err_cnt_o increments by exactly 1.
5. RUN, skew=1, no vld_o_i → FLUSH after 256 cycles with cause_o=11. Repeat with vld_o_i at cycle 200 → no flush until 256 cycles after that.
6. Two further scenarios:
   - en_i dropped in the 2nd FLUSH cycle → state IDLE and flush_o=0 the next cycle.
   - 300 forced skew flushes → err_cnt_o saturates at 255.

Source files
------------

// File: rtl/data_aligner_pkg.sv
// Shared types for the two-stream aligner run-time controller.
package data_aligner_pkg;

  // Scheduler FSM states; encoding is visible on state_o.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    SYNC  = 2'd2,
    RUN   = 2'd3
  } sched_state_t;

  // Reason recorded for the most recent error flush.
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_STATUS  = 2'd1,
    CAUSE_SKEW    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } flush_cause_t;

  // Bit positions inside the aligner FIFO status word.
  localparam int unsigned STATUS_FULL_1ST = 0;
  localparam int unsigned STATUS_FULL_2D  = 1;

endpackage

// File: rtl/aligner_skew_counter.sv
// Signed saturating up/down counter tracking 1st-minus-2d word skew.
module aligner_skew_counter #(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  input  logic                    dec,
  output logic signed [CNT_W-1:0] cnt
);

  // Symmetric saturation limits so that negating the count never overflows.
  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;
  localparam logic signed [CNT_W-1:0] ONE     = 1;

  // Count up on inc alone, down on dec alone; clear and reset take priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of statement or block ordering.
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + ONE;
    end else if (dec && !inc && cnt != CNT_MIN) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/data_aligner_sched.sv
// Run-time controller for the two-stream data aligner: gates input valids,
// tracks skew, and flushes/resynchronises the aligner on drift or stall.
module data_aligner_sched
  import data_aligner_pkg::*;
#(
  parameter int SKEW_MAX     = 8,
  parameter int TIMEOUT      = 256,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    vld_1st_i,
  input  logic                    vld_2d_i,
  input  logic                    vld_o_i,
  input  logic [1:0]              statuses_i,
  output logic                    gate_1st_o,
  output logic                    gate_2d_o,
  output logic                    flush_o,
  output logic [1:0]              state_o,
  output logic signed [CNT_W-1:0] skew_o,
  output logic [1:0]              cause_o,
  output logic [CNT_W-1:0]        err_cnt_o
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sched_state_t            state_q, state_d;
  logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    gate_q, flush_q;
  flush_cause_t            cause_q, cause_hit;
  logic [CNT_W-1:0]        err_cnt_q;
  logic                    err_hit;
  logic                    status_err;
  logic signed [CNT_W-1:0] skew_q;
  logic [CNT_W-1:0]        skew_abs;
  logic                    in_run;

  assign in_run     = (state_q == RUN);
  assign status_err = statuses_i[STATUS_FULL_1ST] | statuses_i[STATUS_FULL_2D];
  assign skew_abs   = skew_q[CNT_W-1] ? $unsigned(-skew_q) : $unsigned(skew_q);

  // Skew only moves in RUN and is held at zero whenever the next state is not RUN.
  aligner_skew_counter #(.CNT_W(CNT_W)) u_skew (
    .clk (clk),
    .rst (rst),
    .clr (state_d != RUN),
    .inc (in_run & vld_1st_i),
    .dec (in_run & vld_2d_i),
    .cnt (skew_q)
  );

  // Prioritised error detection, FSM next state, flush length and stall timer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    flush_cnt_d = '0;
    err_hit     = 1'b0;
    cause_hit   = CAUSE_NONE;

    if (in_run) begin
      if (status_err) begin
        err_hit   = 1'b1;
        cause_hit = CAUSE_STATUS;
      end else if (skew_abs > CNT_W'(SKEW_MAX)) begin
        err_hit   = 1'b1;
        cause_hit = CAUSE_SKEW;
      end else if (timer_q == TMR_W'(TIMEOUT)) begin
        err_hit   = 1'b1;
        cause_hit = CAUSE_TIMEOUT;
      end
    end

    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = FLUSH;
        FLUSH: begin
          if (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1)) state_d = SYNC;
          else flush_cnt_d = flush_cnt_q + 1'b1;
        end
        SYNC:  if (vld_1st_i && vld_2d_i) state_d = RUN;
        RUN:   if (err_hit) state_d = FLUSH;
        default: state_d = IDLE;
      endcase
    end

    // Stall timer runs only while skewed, in RUN, with no aligned output.
    if (state_d != RUN || vld_o_i || skew_q == '0) timer_d = '0;
    else timer_d = timer_q + 1'b1;
  end

  // State, registered outputs, and the persistent error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      timer_q     <= '0;
      gate_q      <= 1'b0;
      flush_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      timer_q     <= timer_d;
      gate_q      <= (state_d == RUN);
      flush_q     <= (state_d == FLUSH);
      if (en_i && err_hit) begin
        cause_q <= cause_hit;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign gate_1st_o = gate_q;
  assign gate_2d_o  = gate_q;
  assign flush_o    = flush_q;
  assign state_o    = state_q;
  assign skew_o     = skew_q;
  assign cause_o    = cause_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
